// File: rtl/slot_game_fsm.sv
// Three-reel slot machine controller: credit handling, reel spin/stop,
// win evaluation with saturating payout and timed result hold.
module slot_game_fsm #(
  parameter int unsigned REEL_DIV     = 4000000,
  parameter int unsigned NUM_SYM      = 10,
  parameter int unsigned HOLD_CYCLES  = 100000000,
  parameter int unsigned PAYOUT       = 10,
  parameter int unsigned INIT_CREDITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic [4:0] state,
  output logic [3:0] reel0,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic [7:0] credits,
  output logic       win_pulse
);

  localparam int unsigned TW =
    (REEL_DIV > 1) ? $clog2(REEL_DIV) : 1;
  localparam int unsigned HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(REEL_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    SYM_MAX  = 4'(NUM_SYM - 1);
  localparam logic [8:0]    PAY9     =
    (PAYOUT > 255) ? 9'd255 : 9'(PAYOUT);

  localparam logic [3:0] R0_INIT = 4'd0;
  localparam logic [3:0] R1_INIT = 4'(3 % NUM_SYM);
  localparam logic [3:0] R2_INIT = 4'(6 % NUM_SYM);

  typedef enum logic [4:0] {
    IDLE  = 5'd0,
    SPIN3 = 5'd1,
    SPIN2 = 5'd2,
    SPIN1 = 5'd3,
    EVAL  = 5'd4,
    LOSE  = 5'd5,
    WIN   = 5'd7
  } state_t;

  state_t        st_q, st_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    r0_d, r1_d, r2_d;
  logic [7:0]    cred_d;
  logic          win_d;
  logic          spinning;
  logic          tick;
  logic          match;
  logic [8:0]    pay_sum;
  logic [7:0]    pay_sat;

  function automatic logic [3:0] adv(input logic [3:0] r);
    return (r == SYM_MAX) ? 4'd0 : r + 4'd1;
  endfunction

  assign spinning = (st_q == SPIN3) ||
                    (st_q == SPIN2) ||
                    (st_q == SPIN1);
  assign tick    = spinning && (tick_q == TICK_MAX);
  assign match   = (reel0 == reel1) && (reel1 == reel2);
  assign pay_sum = {1'b0, credits} + PAY9;
  assign pay_sat = pay_sum[8] ? 8'hFF : pay_sum[7:0];
  assign state   = st_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= IDLE;
      tick_q    <= '0;
      hold_q    <= '0;
      reel0     <= R0_INIT;
      reel1     <= R1_INIT;
      reel2     <= R2_INIT;
      credits   <= 8'(INIT_CREDITS);
      win_pulse <= 1'b0;
    end else begin
      st_q      <= st_d;
      tick_q    <= tick_d;
      hold_q    <= hold_d;
      reel0     <= r0_d;
      reel1     <= r1_d;
      reel2     <= r2_d;
      credits   <= cred_d;
      win_pulse <= win_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    tick_d = '0;
    hold_d = '0;
    r0_d   = reel0;
    r1_d   = reel1;
    r2_d   = reel2;
    cred_d = credits;
    win_d  = 1'b0;

    if (spinning)
      tick_d = tick ? '0 : tick_q + 1'b1;

    // the stop edge itself freezes the reel it targets
    if (tick) begin
      if (st_q == SPIN3 && !stop)
        r0_d = adv(reel0);
      if (st_q == SPIN3 || (st_q == SPIN2 && !stop))
        r1_d = adv(reel1);
      if (st_q != SPIN1 || !stop)
        r2_d = adv(reel2);
    end

    unique case (st_q)
      IDLE: begin
        if (start && credits != 8'd0) begin
          st_d   = SPIN3;
          cred_d = credits - 8'd1;
        end
      end
      SPIN3: if (stop) st_d = SPIN2;
      SPIN2: if (stop) st_d = SPIN1;
      SPIN1: if (stop) st_d = EVAL;
      EVAL: begin
        if (match) begin
          st_d   = WIN;
          cred_d = pay_sat;
          win_d  = 1'b1;
        end else begin
          st_d = LOSE;
        end
      end
      WIN, LOSE: begin
        if (hold_q == HOLD_MAX)
          st_d = IDLE;
        else
          hold_d = hold_q + 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end

endmodule

// File: doc/slot_game_fsm.md
SLOT_GAME_FSM -- requirements
Module: slot_game_fsm

Interface
REQ-001 Parameter REEL_DIV, default 4000000: clock cycles per reel advance tick.
REQ-002 Parameter NUM_SYM, default 10: symbols per reel (2..16), values 0..NUM_SYM-1.
REQ-003 Parameter HOLD_CYCLES, default 100000000: clock cycles spent in WIN/LOSE before returning to IDLE.
REQ-004 Parameter PAYOUT, default 10: credits added on a win.
REQ-005 Parameter INIT_CREDITS, default 20: credit count after reset.
REQ-006 clk  input  1: single system clock; all state changes on its rising edge.
REQ-007 rst  input  1: asynchronous, active-low reset.
REQ-008 start  input  1: one-cycle, pre-debounced start pulse.
REQ-009 stop  input  1: one-cycle, pre-debounced stop pulse.
REQ-010 state  output  5: game state code, registered, consumed by the LED controller.
REQ-011 reel0, reel1, reel2  output  4 each: current reel symbols, registered.
REQ-012 credits  output  8: current credit balance, registered.
REQ-013 win_pulse  output  1: one-cycle pulse on entry to WIN.

Function
REQ-014 State codes SHALL be: IDLE=0, SPIN3=1 (all reels spinning), SPIN2=2 (reel0 stopped), SPIN1=3 (reel0, reel1 stopped), EVAL=4, LOSE=5, WIN=7; code 6 and 8..31 never driven.
REQ-015 IDLE: start with credits>0 -> SPIN3, credits decremented by 1 in the same edge; start with credits==0 -> stay IDLE, no change; stop ignored.
REQ-016 SPIN3 -> SPIN2 on stop; SPIN2 -> SPIN1 on stop; SPIN1 -> EVAL on stop; start ignored in all spin states.
REQ-017 Tick counter SHALL count 0..REEL_DIV-1 and wrap while in SPIN3/SPIN2/SPIN1; it SHALL be cleared to 0 in every other state.
REQ-018 On tick (counter == REEL_DIV-1) each still-spinning reel SHALL advance by 1, wrapping NUM_SYM-1 -> 0; stopped reels hold.
REQ-019 A reel is frozen by the stop edge itself; if tick and stop coincide, the stopping reel SHALL NOT advance, the others SHALL.
REQ-020 EVAL lasts exactly one cycle: reel0==reel1==reel2 -> WIN, else -> LOSE.
REQ-021 On EVAL->WIN, credits += PAYOUT, saturating at 255; win_pulse high for that one following cycle only.
REQ-022 WIN and LOSE SHALL hold for exactly HOLD_CYCLES cycles (hold counter cleared on entry), then go to IDLE; start/stop ignored during hold.
REQ-023 Reels SHALL retain their values through EVAL, WIN, LOSE and IDLE until the next SPIN3 entry; they are not re-seeded on start.
REQ-024 Simultaneous start and stop: only the input meaningful in the current state SHALL act.
REQ-025 All outputs SHALL be driven from flops; no combinational path input -> output.

Reset
REQ-026 On rst low, asynchronously: state=IDLE, reel0=0, reel1=3%NUM_SYM, reel2=6%NUM_SYM, credits=INIT_CREDITS, win_pulse=0, tick and hold counters=0.
REQ-027 Reset asserted mid-spin or mid-hold SHALL abort immediately to REQ-026 values; no credit refund or payout.
REQ-028 After rst release, the first rising edge SHALL evaluate normal IDLE behaviour.

Verification (REEL_DIV=4, NUM_SYM=10, HOLD_CYCLES=16, PAYOUT=10, INIT_CREDITS=20)
REQ-029 Reset release, start pulse -> state 0->1, credits 20->19; reel0 advances 0->1->2 every 4 cycles.
REQ-030 Hold reel0 at 9 across a tick -> reel0 wraps to 0 at the next tick.
REQ-031 Stop timed so all reels read 5 at the third stop -> EVAL one cycle, state=7, credits 19->29, win_pulse one cycle, state=0 after 16 cycles.
REQ-032 Unequal reels at third stop -> state=5, credits unchanged, state=0 after 16 cycles; start during hold ignored.
REQ-033 Force credits=0 (20 losing rounds), then start -> state stays 0; credits=250 plus win -> credits=255.
REQ-034 Assert rst during SPIN2 with stop and tick coincident -> all outputs at REQ-026 values asynchronously, before next clock edge.
